bytecode_fetcher: RTL and testbench
===================================

Name: bytecode_fetcher

Overview:
- Sequences the JVM bytecode front end: consumes a byte stream, classifies each opcode through the shared operand-length ROM (count_rom), and gathers the operand bytes that follow.
- Emits one complete instruction record (opcode, packed operands, operand count, start PC) per handshake to the translation stage.
- Sits between the bytecode memory/prefetch stream and the ARM translation logic. Supports flush/redirect on taken branches.

Parameters:
- PC_W, 16, bytecode address width; PC wraps modulo 2^PC_W.
- MAX_OPS, 16, operand buffer depth in bytes; must be >= 16, the largest ROM count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  redirect request; discards any partial or pending instruction.
- flush_pc  input  PC_W  PC of the next opcode after a flush.
- in_byte  input  8  bytecode stream byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  block accepts in_byte this cycle.
- out_valid  output  1  instruction record is valid.
- out_ready  input  1  consumer accepts the record.
- out_opcode  output  8  opcode byte.
- out_operands  output  MAX_OPS*8  operand bytes; operand i in bits [8i+7:8i], first byte following the opcode at i=0; unused bytes are 0.
- out_count  output  `PARAM_LEN  operand byte count (ROM value).
- out_pc  output  PC_W  address of the opcode byte.

Behaviour:
- Reset (async): state=IDLE, pc=0, operand buffer=0, counter=0, out_valid=0, in_ready=0 during reset. All out_* fields read 0.
- Byte transfer occurs on in_valid & in_ready. Each transfer increments pc by 1, with wrap.
- IDLE: in_ready=1 unless flush is asserted.
  - On transfer, latch opcode, latch out_pc=pc, clear operand buffer, and load count from the ROM.
  - If count=0, go to EMIT. Otherwise set idx=0 and go to OPERANDS.
- OPERANDS: in_ready=1 unless flush is asserted.
  - On transfer, write byte at operand slot idx and increment idx.
  - When idx reaches count-1 on a transfer, go to EMIT.
  - Gaps in in_valid simply stall the block; nothing is lost.
- EMIT: out_valid=1 and in_ready=0.
  - Record fields stay stable until out_valid & out_ready, then return to IDLE.
  - Next opcode can be accepted one cycle after the output handshake; no overlap.
- Latency: opcode accepted in cycle N with k operands means the last operand is accepted in cycle N+k and out_valid rises at N+k+1. For k=0, out_valid rises at N+1.
- Flush has highest priority.
  - In the flush cycle: in_ready=0, so no byte is consumed.
  - Next cycle: state=IDLE, pc=flush_pc, out_valid=0, partial operands discarded.
  - If flush coincides with out_valid & out_ready, the transfer counts as completed and the state still resets.
- Unknown or unlisted opcodes use ROM count 0 and are emitted as single-byte instructions. Legality checking is not done here.
- out_count is the raw `PARAM_LEN-bit ROM output. idx is a `PARAM_LEN-bit counter.
- Reset asserted mid-instruction discards everything and returns to the reset values immediately.

Decomposition:
- Package/header: add to me_consts.vh the state encoding constants (ST_IDLE, ST_OPERANDS, ST_EMIT, 2 bits) and MAX_OPERAND_BYTES=16. Keep `PARAM_LEN there.
- Sub-module: instantiate count_rom combinationally on in_byte. No new sub-module.
- Operand buffer: MAX_OPS x 8 register array flattened onto out_operands.

Test Plan:
- Reset, then stream 0x10 0x2A (bipush) with out_ready=1 -> out_valid two cycles after the opcode is accepted; opcode=0x10, count=1, operands[7:0]=0x2A, rest 0, pc=0.
- Back-to-back 0x60 (iadd) then 0x11 0x12 0x34 (sipush) -> first record count=0, pc=0; second record count=2, operands bytes 0x12,0x34, pc=1; final pc register = 4.
- 0xAA followed by 16 bytes 0x01..0x10, with in_valid toggling every other cycle -> one record, count=16, operand i = i+1, and no byte dropped or duplicated.
- Record held with out_ready=0 for 5 cycles -> out_valid stays 1, fields stable, in_ready=0, pc unchanged; consumed on the first cycle out_ready=1.
- Flush with flush_pc=0x0100 after 0xB8 and 1 of its 2 operands -> no record emitted. Next opcode 0x03 is emitted with pc=0x0100 and count=0.
- Async reset pulse while in OPERANDS -> outputs clear within the reset pulse; subsequent 0x15 0x07 is emitted with pc=0.

Source files
------------

// File: rtl/bytecode_fetcher_pkg.sv
// Shared constants for the bytecode front end: state encoding, operand
// length width and the JVM operand-length table used by count_rom.
package bytecode_fetcher_pkg;

  // Width of an operand byte count; must hold the largest table value (16).
  localparam int PARAM_LEN = 5;

  // Largest number of operand bytes any opcode can carry.
  localparam int MAX_OPERAND_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OPERANDS = 2'd1,
    ST_EMIT     = 2'd2
  } state_t;

  // Operand bytes following each opcode. Variable-length forms
  // (tableswitch/lookupswitch) are given the full buffer; anything not
  // listed is treated as a single-byte instruction.
  function automatic logic [PARAM_LEN-1:0] operand_len(input logic [7:0] op);
    logic [PARAM_LEN-1:0] len;
    len = 5'd0;
    case (op) inside
      8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3a], 8'ha9, 8'hbc:
        len = 5'd1;
      8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'ha8], [8'hb2:8'hb8],
      8'hbb, 8'hbd, 8'hc0, 8'hc1, 8'hc6, 8'hc7:
        len = 5'd2;
      8'hc4, 8'hc5:
        len = 5'd3;
      8'hb9, 8'hba, 8'hc8, 8'hc9:
        len = 5'd4;
      8'haa, 8'hab:
        len = 5'd16;
      default:
        len = 5'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/bytecode_fetcher_count_rom.sv
// Combinational opcode -> operand byte count lookup.
module count_rom
  import bytecode_fetcher_pkg::*;
(
  input  logic [7:0]           opcode,
  output logic [PARAM_LEN-1:0] count
);

  // Pure table lookup, no state.
  always_comb begin
    count = operand_len(opcode);
  end

endmodule

// File: rtl/bytecode_fetcher.sv
// Bytecode fetcher: collects an opcode and its operand bytes from the
// prefetch stream and presents one complete instruction record per
// handshake to the translation stage. Flush redirects the fetch PC.
module bytecode_fetcher
  import bytecode_fetcher_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int MAX_OPS = MAX_OPERAND_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [PC_W-1:0]        flush_pc,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_opcode,
  output logic [MAX_OPS*8-1:0]   out_operands,
  output logic [PARAM_LEN-1:0]   out_count,
  output logic [PC_W-1:0]        out_pc
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t                 state_r;
  logic [PC_W-1:0]        pc_r;
  logic [PC_W-1:0]        out_pc_r;
  logic [7:0]             opcode_r;
  logic [PARAM_LEN-1:0]   count_r;
  logic [PARAM_LEN-1:0]   idx_r;
  logic [7:0]             ops_r [MAX_OPS];
  logic                   out_valid_r;

  logic [PARAM_LEN-1:0]   rom_count_s;
  logic                   in_ready_s;
  logic                   xfer_s;
  logic [MAX_OPS*8-1:0]   ops_flat_s;

  count_rom u_count_rom (
    .opcode (in_byte),
    .count  (rom_count_s)
  );

  // Accept bytes while collecting an instruction; never during reset,
  // flush, or while a finished record waits for the consumer.
  always_comb begin
    in_ready_s = 1'b0;
    if (reset || flush) begin
      in_ready_s = 1'b0;
    end else if (state_r == ST_IDLE || state_r == ST_OPERANDS) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign xfer_s = in_valid & in_ready_s;

  // Flatten the operand slots, slot 0 in the least significant byte.
  always_comb begin
    ops_flat_s = {(MAX_OPS*8){1'b0}};
    for (int i = 0; i < MAX_OPS; i++) begin
      ops_flat_s[8*i +: 8] = ops_r[i];
    end
  end

  // Fetch sequencer: opcode capture, operand gathering, record hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      pc_r        <= {PC_W{1'b0}};
      out_pc_r    <= {PC_W{1'b0}};
      opcode_r    <= 8'h00;
      count_r     <= {PARAM_LEN{1'b0}};
      idx_r       <= {PARAM_LEN{1'b0}};
      out_valid_r <= 1'b0;
      for (int i = 0; i < MAX_OPS; i++) begin
        ops_r[i] <= 8'h00;
      end
    end else if (flush) begin
      // Redirect wins over everything; a record handshaking this cycle
      // is still considered delivered.
      state_r     <= ST_IDLE;
      pc_r        <= flush_pc;
      idx_r       <= {PARAM_LEN{1'b0}};
      out_valid_r <= 1'b0;
      for (int i = 0; i < MAX_OPS; i++) begin
        ops_r[i] <= 8'h00;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (xfer_s) begin
            opcode_r <= in_byte;
            out_pc_r <= pc_r;
            pc_r     <= pc_r + PC_ONE;
            count_r  <= rom_count_s;
            idx_r    <= {PARAM_LEN{1'b0}};
            for (int i = 0; i < MAX_OPS; i++) begin
              ops_r[i] <= 8'h00;
            end
            if (rom_count_s == {PARAM_LEN{1'b0}}) begin
              state_r     <= ST_EMIT;
              out_valid_r <= 1'b1;
            end else begin
              state_r <= ST_OPERANDS;
            end
          end
        end
        ST_OPERANDS: begin
          if (xfer_s) begin
            for (int i = 0; i < MAX_OPS; i++) begin
              if ((i < (2 ** PARAM_LEN)) && (idx_r == PARAM_LEN'(i))) begin
                ops_r[i] <= in_byte;
              end
            end
            idx_r <= idx_r + 5'd1;
            pc_r  <= pc_r + PC_ONE;
            if (idx_r == (count_r - 5'd1)) begin
              state_r     <= ST_EMIT;
              out_valid_r <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_r;
  assign out_opcode   = opcode_r;
  assign out_operands = ops_flat_s;
  assign out_count    = count_r;
  assign out_pc       = out_pc_r;

endmodule

// File: tb/tb_bytecode_fetcher.sv
// Self-checking bench for bytecode_fetcher: directed scenarios with
// literal expectations, then randomized traffic against a
// transaction-level model of the instruction stream.
module tb_bytecode_fetcher;
  import bytecode_fetcher_pkg::*;

  localparam int PC_W    = 16;
  localparam int MAX_OPS = 16;

  logic                  clk;
  logic                  reset;
  logic                  flush;
  logic [PC_W-1:0]       flush_pc;
  logic [7:0]            in_byte;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_opcode;
  logic [MAX_OPS*8-1:0]  out_operands;
  logic [PARAM_LEN-1:0]  out_count;
  logic [PC_W-1:0]       out_pc;

  int n_cmp;
  int n_bad;
  int len_tab [256];

  // model of the instruction stream
  logic [PC_W-1:0] m_pc;
  bit              m_busy;
  int              m_need;
  int              m_got;
  bit              m_rec;
  logic [7:0]      m_op;
  logic [127:0]    m_ops;
  logic [PC_W-1:0] m_opc;
  bit              m_acc;

  bytecode_fetcher #(.PC_W(PC_W), .MAX_OPS(MAX_OPS)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_operands (out_operands),
    .out_count    (out_count),
    .out_pc       (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // JVM operand byte counts
  function automatic void build_table();
    for (int i = 0; i < 256; i++) len_tab[i] = 0;
    len_tab['h10] = 1; len_tab['h12] = 1; len_tab['ha9] = 1; len_tab['hbc] = 1;
    for (int i = 'h15; i <= 'h19; i++) len_tab[i] = 1;
    for (int i = 'h36; i <= 'h3a; i++) len_tab[i] = 1;
    len_tab['h11] = 2; len_tab['h13] = 2; len_tab['h14] = 2; len_tab['h84] = 2;
    for (int i = 'h99; i <= 'ha8; i++) len_tab[i] = 2;
    for (int i = 'hb2; i <= 'hb8; i++) len_tab[i] = 2;
    len_tab['hbb] = 2; len_tab['hbd] = 2; len_tab['hc0] = 2; len_tab['hc1] = 2;
    len_tab['hc6] = 2; len_tab['hc7] = 2;
    len_tab['hc4] = 3; len_tab['hc5] = 3;
    len_tab['hb9] = 4; len_tab['hba] = 4; len_tab['hc8] = 4; len_tab['hc9] = 4;
    len_tab['haa] = 16; len_tab['hab] = 16;
  endfunction

  function automatic void model_reset();
    m_pc = '0; m_busy = 0; m_need = 0; m_got = 0; m_rec = 0;
    m_op = '0; m_ops = '0; m_opc = '0; m_acc = 0;
  endfunction

  // Advance the model by one clock edge using the inputs now applied.
  function automatic void model_step();
    m_acc = 0;
    if (reset) begin
      model_reset();
    end else if (flush) begin
      m_pc = flush_pc; m_busy = 0; m_rec = 0;
    end else if (m_rec) begin
      if (out_ready) m_rec = 0;
    end else if (in_valid) begin
      m_acc = 1;
      if (!m_busy) begin
        m_op = in_byte; m_opc = m_pc; m_ops = '0;
        m_need = len_tab[in_byte]; m_got = 0;
        if (m_need == 0) m_rec = 1;
        else m_busy = 1;
      end else begin
        m_ops[8*m_got +: 8] = in_byte;
        m_got++;
        if (m_got == m_need) begin
          m_busy = 0; m_rec = 1;
        end
      end
      m_pc = m_pc + 16'd1;
    end
  endfunction

  // Compare every observable output with the model.
  task automatic compare();
    if (reset) begin
      model_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_opcode", out_opcode, 0);
      chk("rst_operands", out_operands, 0);
      chk("rst_count", out_count, 0);
      chk("rst_pc", out_pc, 0);
    end else begin
      chk("in_ready", in_ready, !flush && !m_rec);
      chk("out_valid", out_valid, m_rec);
      if (m_rec) begin
        chk("opcode", out_opcode, m_op);
        chk("operands", out_operands, m_ops);
        chk("count", out_count, m_need);
        chk("pc", out_pc, m_opc);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_byte  = b;
    for (int t = 0; t < 64 && !done; t++) begin
      tick();
      if (m_acc) done = 1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: byte %0h not accepted within 64 cycles", b);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [7:0] picks [12] = '{8'h10, 8'h11, 8'h60, 8'h00, 8'hAA, 8'hB9,
                             8'hC4, 8'h84, 8'h15, 8'hA7, 8'hC8, 8'hFF};

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; flush = 1'b0; flush_pc = '0; in_byte = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    build_table();
    model_reset();
    chk("tab_aa", len_tab['haa], 16);
    chk("tab_11", len_tab['h11], 2);
    @(posedge clk); #1;
    do_reset();

    // bipush 0x2A
    out_ready = 1'b1;
    send_byte(8'h10);
    chk("t1_not_yet", out_valid, 0);
    send_byte(8'h2A);
    chk("t1_valid", out_valid, 1);
    chk("t1_opcode", out_opcode, 8'h10);
    chk("t1_ops", out_operands, 128'h2A);
    chk("t1_count", out_count, 5'd1);
    chk("t1_pc", out_pc, 16'h0000);
    tick();
    chk("t1_consumed", out_valid, 0);

    // iadd then sipush 0x1234
    do_reset();
    send_byte(8'h60);
    chk("t2a_valid", out_valid, 1);
    chk("t2a_opcode", out_opcode, 8'h60);
    chk("t2a_count", out_count, 5'd0);
    chk("t2a_pc", out_pc, 16'h0000);
    send_byte(8'h11);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("t2b_opcode", out_opcode, 8'h11);
    chk("t2b_count", out_count, 5'd2);
    chk("t2b_ops", out_operands, 128'h3412);
    chk("t2b_pc", out_pc, 16'h0001);
    send_byte(8'h00);
    chk("t2c_pc", out_pc, 16'h0004);
    tick();

    // tableswitch with 16 operands, in_valid toggling
    do_reset();
    send_byte(8'hAA);
    for (int i = 1; i <= 16; i++) begin
      tick();
      send_byte(8'(i));
    end
    chk("t3_valid", out_valid, 1);
    chk("t3_count", out_count, 5'd16);
    chk("t3_ops", out_operands, 128'h100f0e0d0c0b0a090807060504030201);
    chk("t3_pc", out_pc, 16'h0000);
    tick();

    // record held under back-pressure
    do_reset();
    out_ready = 1'b0;
    send_byte(8'h15);
    send_byte(8'h07);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_ready", in_ready, 0);
      chk("t4_hold_ops", out_operands, 128'h07);
      chk("t4_hold_pc", out_pc, 16'h0000);
    end
    out_ready = 1'b1;
    tick();
    chk("t4_consumed", out_valid, 0);
    send_byte(8'h00);
    chk("t4_next_pc", out_pc, 16'h0002);
    tick();

    // flush mid-instruction
    do_reset();
    send_byte(8'hB8);
    send_byte(8'h00);
    flush = 1'b1; flush_pc = 16'h0100; in_valid = 1'b1; in_byte = 8'h55;
    #1;
    chk("t5_flush_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_no_record", out_valid, 0);
    send_byte(8'h03);
    chk("t5_valid", out_valid, 1);
    chk("t5_opcode", out_opcode, 8'h03);
    chk("t5_pc", out_pc, 16'h0100);
    chk("t5_count", out_count, 5'd0);
    tick();

    // async reset while gathering operands
    do_reset();
    send_byte(8'h10);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_ready", in_ready, 0);
    chk("t6_async_opcode", out_opcode, 8'h00);
    tick();
    reset = 1'b0;
    send_byte(8'h15);
    send_byte(8'h07);
    chk("t6_opcode", out_opcode, 8'h15);
    chk("t6_ops", out_operands, 128'h07);
    chk("t6_pc", out_pc, 16'h0000);
    tick();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(399) == 0);
      flush     = ($urandom_range(39) == 0);
      flush_pc  = 16'($urandom);
      in_valid  = ($urandom_range(9) < 7);
      in_byte   = ($urandom_range(9) < 6) ? picks[$urandom_range(11)] : 8'($urandom);
      out_ready = ($urandom_range(9) < 6);
      tick();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
